// File: rtl/vga_mono_pipe.sv
// vga_mono_pipe: registered 3-stage video post-processor with frame-synchronous monochrome mode switching.
// Ports:
//   clk_vga                  pixel clock
//   rst                      asynchronous active-high reset
//   r_in, g_in, b_in         6-bit pixel colour from the core
//   hsync_in, vsync_in       syncs from the core (polarity set by HS_/VS_ACTIVE_LOW)
//   mode_req                 requested mode (00 colour, 01 green, 10 amber, 11 grey)
//   cycle_pulse              one-cycle hotkey pulse advancing the pending mode
//   r_out, g_out, b_out      processed pixel, 3 cycles after input
//   hsync_out, vsync_out     syncs delayed to match the pixels
//   mode_active              mode currently bound to entering pixels
module vga_mono_pipe #(
    parameter bit HS_ACTIVE_LOW = 1'b1,
    parameter bit VS_ACTIVE_LOW = 1'b1
) (
    input  logic       clk_vga,
    input  logic       rst,
    input  logic [5:0] r_in,
    input  logic [5:0] g_in,
    input  logic [5:0] b_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [1:0] mode_req,
    input  logic       cycle_pulse,
    output logic [5:0] r_out,
    output logic [5:0] g_out,
    output logic [5:0] b_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [1:0] mode_active
);
    localparam logic HS_OFF = HS_ACTIVE_LOW;
    localparam logic VS_OFF = VS_ACTIVE_LOW;
    localparam logic VS_ON  = !VS_ACTIVE_LOW;

    logic [1:0]  mode_req_q, pending;
    logic        vs_q, boundary;
    logic [5:0]  r1, g1, b1, r2, g2, b2, y2;
    logic        hs1, vs1, hs2, vs2;
    logic [1:0]  m1, m2;
    logic [11:0] y_sum;
    logic [5:0]  r_mux, g_mux, b_mux;

    assign boundary = (vsync_in == VS_ON) && (vs_q != VS_ON);

    // A mode_req edge outranks a same-cycle hotkey pulse; the pending value
    // loaded at a boundary is the one registered before that edge.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            mode_req_q  <= 2'd0;
            pending     <= 2'd0;
            mode_active <= 2'd0;
            vs_q        <= VS_OFF;
        end else begin
            mode_req_q <= mode_req;
            vs_q       <= vsync_in;
            if (boundary)
                mode_active <= pending;
            pending <= (mode_req != mode_req_q) ? mode_req :
                       cycle_pulse ? pending + 2'd1 : pending;
        end
    end

    // Rec.709 luma with coefficients summing to 64, so the result never exceeds 63.
    assign y_sum = 12'd13 * 12'(r1) + 12'd46 * 12'(g1) + 12'd5 * 12'(b1);

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            {r1, g1, b1, m1} <= '0;
            hs1              <= HS_OFF;
            vs1              <= VS_OFF;
            {r2, g2, b2, y2, m2} <= '0;
            hs2              <= HS_OFF;
            vs2              <= VS_OFF;
            {r_out, g_out, b_out} <= '0;
            hsync_out        <= HS_OFF;
            vsync_out        <= VS_OFF;
        end else begin
            {r1, g1, b1, m1} <= {r_in, g_in, b_in, mode_active};
            hs1              <= hsync_in;
            vs1              <= vsync_in;
            {r2, g2, b2, m2} <= {r1, g1, b1, m1};
            y2               <= y_sum[11:6];
            hs2              <= hs1;
            vs2              <= vs1;
            {r_out, g_out, b_out} <= {r_mux, g_mux, b_mux};
            hsync_out        <= hs2;
            vsync_out        <= vs2;
        end
    end

    always_comb begin
        r_mux = (m2 == 2'd0) ? r2 : (m2 == 2'd1) ? 6'd0 : y2;
        g_mux = (m2 == 2'd0) ? g2 : (m2 == 2'd2) ? {1'b0, y2[5:1]} : y2;
        b_mux = (m2 == 2'd0) ? b2 : (m2 == 2'd3) ? y2 : 6'd0;
    end
endmodule

// File: tb/tb_vga_mono_pipe.sv
// tb_vga_mono_pipe: randomized and directed self-checking bench against a frame-level reference model.
module tb_vga_mono_pipe;
    logic       clk_vga = 1'b0;
    logic       rst;
    logic [5:0] r_in, g_in, b_in, r_out, g_out, b_out;
    logic       hsync_in, vsync_in, cycle_pulse, hsync_out, vsync_out;
    logic [1:0] mode_req, mode_active;

    vga_mono_pipe dut (
        .clk_vga(clk_vga), .rst(rst),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .mode_req(mode_req), .cycle_pulse(cycle_pulse),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .mode_active(mode_active)
    );

    always #5 clk_vga = ~clk_vga;

    typedef struct {
        logic [5:0] r, g, b;
        logic       hs, vs;
    } pix_t;

    int n_cmp = 0;
    int n_bad = 0;

    pix_t q[$];
    pix_t cur_exp;
    int   m_pend, m_reqq, m_act;
    logic m_vsq;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Expected output of one pixel under a mode, from the luma definition.
    function automatic pix_t xform(input int r, input int g, input int b, input logic hs, input logic vs, input int mode);
        pix_t p;
        int y;
        y = (13 * r + 46 * g + 5 * b) / 64;
        p.hs = hs;
        p.vs = vs;
        if (mode == 0) begin p.r = 6'(r); p.g = 6'(g); p.b = 6'(b); end
        else if (mode == 1) begin p.r = 0; p.g = 6'(y); p.b = 0; end
        else if (mode == 2) begin p.r = 6'(y); p.g = 6'(y / 2); p.b = 0; end
        else begin p.r = 6'(y); p.g = 6'(y); p.b = 6'(y); end
        return p;
    endfunction

    task automatic model_reset();
        pix_t z;
        z = xform(0, 0, 0, 1'b1, 1'b1, 0);
        m_pend = 0; m_reqq = 0; m_act = 0; m_vsq = 1'b1;
        q = {z, z};
        cur_exp = z;
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_r"}, 8'(r_out), 8'(cur_exp.r));
        check({tag, "_g"}, 8'(g_out), 8'(cur_exp.g));
        check({tag, "_b"}, 8'(b_out), 8'(cur_exp.b));
        check({tag, "_hs"}, 8'(hsync_out), 8'(cur_exp.hs));
        check({tag, "_vs"}, 8'(vsync_out), 8'(cur_exp.vs));
        check({tag, "_mode"}, 8'(mode_active), 8'(m_act));
    endtask

    // One clock: advance the model with the inputs sampled at the edge, then compare on the falling edge.
    task automatic step();
        bit bnd;
        @(posedge clk_vga);
        bnd = (vsync_in == 1'b0) && (m_vsq != 1'b0);
        q.push_back(xform(r_in, g_in, b_in, hsync_in, vsync_in, m_act));
        cur_exp = q.pop_front();
        if (bnd) m_act = m_pend;
        if (mode_req != 2'(m_reqq)) m_pend = mode_req;
        else if (cycle_pulse) m_pend = (m_pend + 1) % 4;
        m_reqq = mode_req;
        m_vsq = vsync_in;
        @(negedge clk_vga);
        check_outs("cyc");
    endtask

    task automatic pix(input int r, input int g, input int b);
        r_in = 6'(r); g_in = 6'(g); b_in = 6'(b);
    endtask

    task automatic idle_inputs();
        pix(0, 0, 0);
        hsync_in = 1'b1; vsync_in = 1'b1; cycle_pulse = 1'b0; mode_req = 2'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        #1;
        model_reset();
        @(negedge clk_vga);
        @(negedge clk_vga);
        check_outs("rst");
        rst = 1'b0;
    endtask

    task automatic frame();
        vsync_in = 1'b0;
        step();
        vsync_in = 1'b1;
        step();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        do_reset();

        // colour passthrough with asserted hsync
        pix(5, 40, 63); hsync_in = 1'b0; step();
        pix(0, 0, 0); hsync_in = 1'b1; step(); step();
        check("pass_r", 8'(r_out), 8'd5);
        check("pass_g", 8'(g_out), 8'd40);
        check("pass_b", 8'(b_out), 8'd63);
        check("pass_hs", 8'(hsync_out), 8'd0);

        // luma modes
        do_reset();
        mode_req = 2'd1; step(); frame();
        pix(63, 63, 63); step(); pix(0, 0, 0); step(); step();
        check("green", 8'({r_out, g_out, b_out} == {6'd0, 6'd63, 6'd0}), 8'd1);
        mode_req = 2'd2; step(); frame();
        pix(63, 0, 0); step(); pix(0, 0, 0); step(); step();
        check("amber", 8'({r_out, g_out, b_out} == {6'd12, 6'd6, 6'd0}), 8'd1);
        mode_req = 2'd3; step(); frame();
        pix(0, 32, 0); step(); pix(0, 0, 0); step(); step();
        check("grey", 8'({r_out, g_out, b_out} == {6'd23, 6'd23, 6'd23}), 8'd1);

        // deferred switch: pixel on the boundary edge keeps colour, the next is grey
        do_reset();
        mode_req = 2'd3;
        repeat (4) begin pix($urandom_range(0, 63), $urandom_range(0, 63), 0); step(); end
        check("defer_hold", 8'(mode_active), 8'd0);
        pix(5, 40, 63); vsync_in = 1'b0; step();
        check("defer_sw", 8'(mode_active), 8'd3);
        pix(0, 32, 0); vsync_in = 1'b1; step();
        pix(0, 0, 0); step();
        check("defer_old", 8'({r_out, g_out, b_out} == {6'd5, 6'd40, 6'd63}), 8'd1);
        step();
        check("defer_new", 8'({r_out, g_out, b_out} == {6'd23, 6'd23, 6'd23}), 8'd1);

        // hotkey cycling, one pulse per frame
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            cycle_pulse = 1'b1; step(); cycle_pulse = 1'b0; step();
            frame();
            check("hotkey", 8'(mode_active), 8'(k % 4));
        end
        // two pulses in one frame
        do_reset();
        cycle_pulse = 1'b1; step(); cycle_pulse = 1'b0; step();
        cycle_pulse = 1'b1; step(); cycle_pulse = 1'b0; step();
        frame();
        check("hotkey2", 8'(mode_active), 8'd2);

        // simultaneous mode_req change and pulse: pulse is dropped
        do_reset();
        mode_req = 2'd2; cycle_pulse = 1'b1; step(); cycle_pulse = 1'b0; step();
        frame();
        check("simul", 8'(mode_active), 8'd2);

        // async reset mid-line in grey mode
        mode_req = 2'd3; step(); frame();
        hsync_in = 1'b0;
        repeat (3) begin pix($urandom_range(1, 63), 63, $urandom_range(0, 63)); step(); end
        #2 rst = 1'b1;
        #1;
        check("arst_r", 8'(r_out), 8'd0);
        check("arst_g", 8'(g_out), 8'd0);
        check("arst_hs", 8'(hsync_out), 8'd1);
        check("arst_vs", 8'(vsync_out), 8'd1);
        check("arst_mode", 8'(mode_active), 8'd0);
        do_reset();
        pix(17, 33, 49); step(); pix(0, 0, 0); step(); step();
        check("post_rst", 8'({r_out, g_out, b_out} == {6'd17, 6'd33, 6'd49}), 8'd1);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            pix($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
            hsync_in = ($urandom_range(0, 7) != 0);
            vsync_in = !((i % 83) < 2 || $urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) == 0) mode_req = 2'($urandom_range(0, 3));
            cycle_pulse = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_mono_pipe.md
# vga_mono_pipe

Registered video post-processor between the system core's 6-bit RGB/sync outputs and the board VGA pins. Converts colour pixels to green, amber or grey monochrome using an integer Rec.709 luma. Delays hsync/vsync to match the pixel pipeline. Defers every display-mode change to the start of the next frame, so no frame ever shows mixed modes.

## Interface
Parameters:
- HS_ACTIVE_LOW, default 1: hsync asserted level is 0 when set.
- VS_ACTIVE_LOW, default 1: vsync asserted level is 0 when set.

Ports:
- clk_vga  in  1  pixel clock. Single clock domain.
- rst  in  1  reset. Asynchronous, active-high.
- r_in, g_in, b_in  in  6 each  pixel colour from the core.
- hsync_in, vsync_in  in  1 each  syncs from the core, polarity per parameters.
- mode_req  in  2  requested mode from the core's monochrome switcher.
- cycle_pulse  in  1  one-cycle pulse that advances the mode (hotkey).
- r_out, g_out, b_out  out  6 each  processed pixel.
- hsync_out, vsync_out  out  1 each  syncs delayed to match the pixels.
- mode_active  out  2  mode currently applied to entering pixels.

## Operation
- Mode encoding: 00 colour, 01 green, 10 amber, 11 grey.
- Luma: Y = (13·R + 46·G + 5·B) >> 6.
  - 12-bit unsigned intermediate.
  - Coefficients sum to 64, so Y ≤ 63. No saturation is needed.
- Outputs per mode:
  - colour: (R, G, B)
  - green: (0, Y, 0)
  - amber: (Y, Y>>1, 0)
  - grey: (Y, Y, Y)
- mode_req_q is a one-cycle registered copy of mode_req, used for change detection.
- The pending mode register updates every cycle by priority:
  - mode_req ≠ mode_req_q: pending ← mode_req. A mode_req change beats a simultaneous cycle_pulse; the pulse is dropped.
  - else cycle_pulse: pending ← pending+1, with 11 wrapping to 00.
  - else: hold.
- Frame-boundary detection: vs_q registers vsync_in. A frame boundary is the cycle where vsync_in is at its asserted level and vs_q is not.
- At a frame boundary, mode_active ← pending.
  - The pending value used is the one registered before that cycle.
  - A pending update in the same cycle takes effect at the next boundary.
- Each pixel captures mode_active when it enters stage 1. It carries that mode through the pipeline, so the mode is bound per pixel, not per output cycle.
- Pipeline, one stage per cycle:
  - S1: register RGB, syncs, mode; form the three products.
  - S2: sum, shift, register Y together with the RGB, syncs and mode.
  - S3: mode mux into the output registers.
- Syncs pass through an identical 3-stage delay, unmodified.

## Timing
- Latency is exactly 3 clk_vga cycles from the input sample edge to the output for pixels and syncs. Throughput is 1 pixel/cycle with no stalls.
- mode_active changes on the clock edge that samples the frame-boundary condition. The pixel sampled on that same edge still uses the old mode; the next pixel uses the new mode.
- Reset is asynchronous and holds while rst=1:
  - r_out/g_out/b_out = 0.
  - hsync_out = HS_ACTIVE_LOW ? 1 : 0.
  - vsync_out = VS_ACTIVE_LOW ? 1 : 0.
  - mode_active = pending = mode_req_q = 00.
  - vs_q = deasserted level.
  - All pipeline registers hold the same values.
- Reset mid-frame: no frame boundary fires in the first cycle after release unless vsync_in is asserted then. In that case mode_active loads pending = 00.
- Change detection after reset: mode_req_q resets to 00.
  - A nonzero mode_req held through reset is seen as a change in the first cycle after release.
  - That value becomes active at the next frame boundary.
- cycle_pulse held high for N cycles advances pending N times, modulo 4.

## Test plan
- Colour passthrough, mode 00: drive (R,G,B) = (5,40,63), hsync asserted, on cycle t. Expect (5,40,63) and asserted hsync_out on cycle t+3; other inputs pass through unchanged.
- Luma modes: (63,63,63) in green gives (0,63,0). (63,0,0) in amber gives Y=12 and output (12,6,0). (0,32,0) in grey gives (23,23,23).
- Deferred switch: with mode 00, change mode_req to 11 mid-frame. mode_active stays 00 until the vsync-assertion edge; pixels after that edge are grey. Pixels in flight at the edge keep the colour mode.
- Hotkey cycling:
  - Four cycle_pulse pulses, each in a separate frame, starting from 00: mode_active reads 01, 10, 11, 00 at successive frame boundaries.
  - Two pulses within one frame: the next frame shows 10.
- Simultaneous events: in the same cycle, mode_req changes 00→10 and cycle_pulse=1. Pending becomes 10, not 01.
- Async reset mid-line in grey mode: assert rst between clock edges. Outputs go immediately to 0 with syncs inactive and mode_active=00. After release, colour pixels pass through with 3-cycle latency.
